// File: rtl/uart_ram_tx_streamer_if.sv
// RAM read port between the TX streamer and the frame RAM.
//  ram_en_o    1-cycle read enable, one pulse per byte fetched
//  ram_addr_o  read address, ADDR_W bits
//  ram_data_i  read data, valid the cycle after ram_en_o
// master = streamer side, slave = RAM side.
interface uart_ram_tx_streamer_if #(
  parameter int ADDR_W = 17
) ();
  logic              ram_en_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [7:0]        ram_data_i;

  modport master (output ram_en_o, output ram_addr_o, input ram_data_i);
  modport slave  (input ram_en_o, input ram_addr_o, output ram_data_i);
endinterface

// File: rtl/uart_ram_tx_streamer.sv
// Streams a block of bytes from the frame RAM out as 8N1 UART frames, optionally
// followed by an XOR checksum frame.
//  clk_i, rst_i      clock, synchronous active-high reset
//  start_i           start request (honoured only while idle)
//  base_addr_i       first RAM address
//  length_i          number of data bytes
//  baud_div_i        clocks per bit (values below 2 are treated as 2)
//  ram               RAM read port (en / addr / data, data one clock after en)
//  uart_tx_o         serial line, idle high
//  busy_o            transfer in progress
//  byte_sent_o       pulse in last cycle of every stop bit
//  done_o            pulse when a transfer ends
//  byte_count_o      data bytes fully sent in current/last transfer
// All outputs are registered.
module uart_ram_tx_streamer #(
  parameter int ADDR_W      = 17,
  parameter int BAUD_W      = 16,
  parameter bit CHECKSUM_EN = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     base_addr_i,
  input  logic [ADDR_W-1:0]     length_i,
  input  logic [BAUD_W-1:0]     baud_div_i,
  uart_ram_tx_streamer_if.master ram,
  output logic                  uart_tx_o,
  output logic                  busy_o,
  output logic                  byte_sent_o,
  output logic                  done_o,
  output logic [ADDR_W-1:0]     byte_count_o
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_REQ, ST_RD_WAIT, ST_START,
    ST_DATA, ST_STOP, ST_CKSUM_START, ST_FIN
  } state_t;

  state_t            state_r, state_s;
  logic [BAUD_W-1:0] cnt_r, cnt_s, bd_r, bd_s;
  logic [2:0]        bit_r, bit_s;
  logic [ADDR_W-1:0] idx_r, idx_s, len_r, len_s;
  logic [ADDR_W-1:0] ram_addr_r, ram_addr_s, count_r, count_s;
  logic [7:0]        shreg_r, shreg_s, cksum_r, cksum_s;
  logic              ck_r, ck_s, ram_en_r, ram_en_s, tx_r, tx_s;
  logic              busy_r, busy_s, bs_r, bs_s, done_r, done_s;
  logic              bit_end_s, more_s;

  // Bit-timing and remaining-bytes decode; idx_r is the index of the byte on the line.
  always_comb begin
    bit_end_s = (cnt_r == bd_r - BAUD_W'(1));
    more_s    = ((idx_r + ADDR_W'(1)) != len_r);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s    = state_r;
    cnt_s      = BAUD_W'(0);
    bd_s       = bd_r;
    bit_s      = bit_r;
    idx_s      = idx_r;
    len_s      = len_r;
    shreg_s    = shreg_r;
    cksum_s    = cksum_r;
    ck_s       = ck_r;
    ram_en_s   = 1'b0;
    ram_addr_s = ram_addr_r;
    busy_s     = busy_r;
    bs_s       = 1'b0;
    done_s     = 1'b0;
    count_s    = count_r;
    tx_s       = 1'b1;
    case (state_r)
      ST_IDLE, ST_FIN: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        if (start_i) begin
          count_s = {ADDR_W{1'b0}};
          cksum_s = 8'h00;
          if (length_i != {ADDR_W{1'b0}}) begin
            state_s    = ST_RD_REQ;
            busy_s     = 1'b1;
            len_s      = length_i;
            bd_s       = (baud_div_i < BAUD_W'(2)) ? BAUD_W'(2) : baud_div_i;
            idx_s      = {ADDR_W{1'b0}};
            ck_s       = 1'b0;
            ram_en_s   = 1'b1;
            ram_addr_s = base_addr_i;
          end else begin
            // empty transfer: report completion without touching RAM or the line
            done_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        state_s = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        shreg_s = ram.ram_data_i;
        cksum_s = cksum_r ^ ram.ram_data_i;
        state_s = ST_START;
      end
      ST_START, ST_CKSUM_START: begin
        if (bit_end_s) begin
          state_s = ST_DATA;
          bit_s   = 3'd0;
        end else begin
          cnt_s = cnt_r + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          if (bit_r == 3'd7) begin
            state_s = ST_STOP;
            // prefetch the next byte during the first stop-bit cycle
            if (!ck_r && more_s) begin
              ram_en_s   = 1'b1;
              ram_addr_s = ram_addr_r + ADDR_W'(1);
            end else begin
              ram_en_s = 1'b0;
            end
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        // registered pulse lands in the last stop-bit cycle (bd >= 2 guarantees this slot)
        if (cnt_r == bd_r - BAUD_W'(2)) begin
          bs_s = 1'b1;
          if (!ck_r) begin
            count_s = count_r + ADDR_W'(1);
          end else begin
            count_s = count_r;
          end
        end else begin
          bs_s = 1'b0;
        end
        // prefetched data is valid in the second stop-bit cycle
        if ((cnt_r == BAUD_W'(1)) && !ck_r && more_s) begin
          shreg_s = ram.ram_data_i;
          cksum_s = cksum_r ^ ram.ram_data_i;
        end else begin
          shreg_s = shreg_r;
        end
        if (bit_end_s) begin
          if (!ck_r && more_s) begin
            state_s = ST_START;
            idx_s   = idx_r + ADDR_W'(1);
          end else if (!ck_r && CHECKSUM_EN) begin
            state_s = ST_CKSUM_START;
            shreg_s = cksum_r;
            ck_s    = 1'b1;
          end else begin
            state_s = ST_FIN;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + BAUD_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    // line level for the cycle the next state occupies
    case (state_s)
      ST_START, ST_CKSUM_START: tx_s = 1'b0;
      ST_DATA:                  tx_s = shreg_s[bit_s];
      default:                  tx_s = 1'b1;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      cnt_r      <= BAUD_W'(0);
      bd_r       <= BAUD_W'(2);
      bit_r      <= 3'd0;
      idx_r      <= {ADDR_W{1'b0}};
      len_r      <= {ADDR_W{1'b0}};
      shreg_r    <= 8'h00;
      cksum_r    <= 8'h00;
      ck_r       <= 1'b0;
      ram_en_r   <= 1'b0;
      ram_addr_r <= {ADDR_W{1'b0}};
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      bs_r       <= 1'b0;
      done_r     <= 1'b0;
      count_r    <= {ADDR_W{1'b0}};
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      bd_r       <= bd_s;
      bit_r      <= bit_s;
      idx_r      <= idx_s;
      len_r      <= len_s;
      shreg_r    <= shreg_s;
      cksum_r    <= cksum_s;
      ck_r       <= ck_s;
      ram_en_r   <= ram_en_s;
      ram_addr_r <= ram_addr_s;
      tx_r       <= tx_s;
      busy_r     <= busy_s;
      bs_r       <= bs_s;
      done_r     <= done_s;
      count_r    <= count_s;
    end
  end

  assign ram.ram_en_o   = ram_en_r;
  assign ram.ram_addr_o = ram_addr_r;
  assign uart_tx_o      = tx_r;
  assign busy_o         = busy_r;
  assign byte_sent_o    = bs_r;
  assign done_o         = done_r;
  assign byte_count_o   = count_r;

endmodule
